// File: rtl/mtr_drv.sv
// Dual H-bridge PWM driver: turns signed-magnitude wheel commands into forward/reverse
// leg drives from one shared 11-bit timebase, with dead time on every direction reversal.

module mtr_drv_side #(
   parameter int DEAD_CYCLES = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [10:0] cnt,
   input  logic        boundary,
   input  logic [10:0] spd,
   input  logic        rev,
   output logic        fwd_pwm,
   output logic        rev_pwm
);

   typedef enum logic [1:0] {
      FWD  = 2'd0,
      REV  = 2'd1,
      DEAD = 2'd2
   } state_t;

   localparam logic [7:0] DEAD_LOAD = 8'(DEAD_CYCLES);

   state_t      state;
   logic [10:0] duty_reg;
   logic [7:0]  dead_cnt;
   logic        tgt_dir;
   logic        active;
   logic        cur_dir;

   assign active  = (cnt < duty_reg);
   assign cur_dir = (state == REV);

   // NOTE: every register here is written with <= so all of them see the pre-edge
   // values of state/cnt/duty_reg; blocking writes would let one leg see the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= FWD;
         duty_reg <= '0;
         dead_cnt <= '0;
         tgt_dir  <= 1'b0;
         fwd_pwm  <= 1'b0;
         rev_pwm  <= 1'b0;
      end else begin
         // Legs can only be high in a settled direction, so DEAD and a flip are always low.
         fwd_pwm <= en & (state == FWD) & active;
         rev_pwm <= en & (state == REV) & active;

         if (boundary) begin
            duty_reg <= spd;
         end

         case (state)
            FWD, REV: begin
               if (boundary && (rev != cur_dir)) begin
                  state    <= DEAD;
                  dead_cnt <= DEAD_LOAD;
                  tgt_dir  <= rev;
               end
            end
            DEAD: begin
               dead_cnt <= dead_cnt - 8'd1;
               if (dead_cnt == 8'd1) begin
                  state <= tgt_dir ? REV : FWD;
               end
            end
            default: state <= FWD;
         endcase
      end
   end

endmodule

module mtr_drv #(
   parameter int DEAD_CYCLES = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [10:0] lft_spd,
   input  logic        lft_rev,
   input  logic [10:0] rght_spd,
   input  logic        rght_rev,
   output logic        lft_fwd_pwm,
   output logic        lft_rev_pwm,
   output logic        rght_fwd_pwm,
   output logic        rght_rev_pwm,
   output logic        period_sync
);

   logic [10:0] cnt;
   logic        boundary;

   assign boundary = (cnt == 11'h7FF);

   // period_sync is registered, so it is decoded one count early to land on cnt==2047.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt         <= '0;
         period_sync <= 1'b0;
      end else begin
         cnt         <= cnt + 11'd1;
         period_sync <= (cnt == 11'h7FE);
      end
   end

   mtr_drv_side #(.DEAD_CYCLES(DEAD_CYCLES)) u_lft (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .cnt      (cnt),
      .boundary (boundary),
      .spd      (lft_spd),
      .rev      (lft_rev),
      .fwd_pwm  (lft_fwd_pwm),
      .rev_pwm  (lft_rev_pwm)
   );

   mtr_drv_side #(.DEAD_CYCLES(DEAD_CYCLES)) u_rght (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .cnt      (cnt),
      .boundary (boundary),
      .spd      (rght_spd),
      .rev      (rght_rev),
      .fwd_pwm  (rght_fwd_pwm),
      .rev_pwm  (rght_rev_pwm)
   );

endmodule

// File: tb/tb_mtr_drv.sv
// Bench for mtr_drv: a per-cycle behavioural model checked on every falling edge, plus
// hand-computed per-period high counts for each directed scenario.

module tb_mtr_drv;

   localparam int DEAD = 32;

   logic        clk = 1'b0;
   logic        rst, en;
   logic [10:0] lft_spd, rght_spd;
   logic        lft_rev, rght_rev;
   logic        lft_fwd_pwm, lft_rev_pwm, rght_fwd_pwm, rght_rev_pwm, period_sync;

   mtr_drv #(.DEAD_CYCLES(DEAD)) dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .lft_spd      (lft_spd),
      .lft_rev      (lft_rev),
      .rght_spd     (rght_spd),
      .rght_rev     (rght_rev),
      .lft_fwd_pwm  (lft_fwd_pwm),
      .lft_rev_pwm  (lft_rev_pwm),
      .rght_fwd_pwm (rght_fwd_pwm),
      .rght_rev_pwm (rght_rev_pwm),
      .period_sync  (period_sync)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: position in period, latched duty, settled direction and remaining dead cycles.
   bit   m_valid = 1'b0;
   int   m_cnt;
   int   m_duty [2];
   int   m_dir  [2];
   int   m_dead [2];
   logic exp_fwd [2];
   logic exp_rev [2];
   int   in_spd [2];
   int   in_rev [2];

   always @(posedge clk) begin
      in_spd[0] = int'(lft_spd);
      in_spd[1] = int'(rght_spd);
      in_rev[0] = int'(lft_rev);
      in_rev[1] = int'(rght_rev);
      if (rst) begin
         m_valid = 1'b1;
         m_cnt   = 0;
         for (int s = 0; s < 2; s++) begin
            m_duty[s]  = 0;
            m_dir[s]   = 0;
            m_dead[s]  = 0;
            exp_fwd[s] = 1'b0;
            exp_rev[s] = 1'b0;
         end
      end else if (m_valid) begin
         for (int s = 0; s < 2; s++) begin
            exp_fwd[s] = en && (m_dead[s] == 0) && (m_dir[s] == 0) && (m_cnt < m_duty[s]);
            exp_rev[s] = en && (m_dead[s] == 0) && (m_dir[s] == 1) && (m_cnt < m_duty[s]);
            if (m_cnt == 2047) begin
               m_duty[s] = in_spd[s];
               if (m_dead[s] == 0 && in_rev[s] != m_dir[s]) begin
                  m_dir[s]  = in_rev[s];
                  m_dead[s] = DEAD;
               end
            end else if (m_dead[s] > 0) begin
               m_dead[s]--;
            end
         end
         m_cnt = (m_cnt + 1) % 2048;
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         check("lft_fwd",    lft_fwd_pwm,  exp_fwd[0]);
         check("lft_rev",    lft_rev_pwm,  exp_rev[0]);
         check("rght_fwd",   rght_fwd_pwm, exp_fwd[1]);
         check("rght_rev",   rght_rev_pwm, exp_rev[1]);
         check("period_sync", period_sync, (m_cnt == 2047));
         check("lft_excl",   lft_fwd_pwm & lft_rev_pwm, 0);
         check("rght_excl",  rght_fwd_pwm & rght_rev_pwm, 0);
      end
   end

   int c_lf, c_lr, c_rf, c_rr, c_ps;
   logic ps_last;

   task automatic sync_to_boundary();
      bit found = 1'b0;
      for (int i = 0; i < 4096; i++) begin
         @(negedge clk);
         if (period_sync === 1'b1) begin
            found = 1'b1;
            break;
         end
      end
      check("sync_found", found, 1);
   endtask

   // One full period window (cnt 0..2047 as seen on the outputs); kind 1 loads new
   // inputs at index ev_at, kind 2 drops en for 100 cycles starting at ev_at.
   task automatic run_period(input int ev_at, input int kind,
                             input logic [10:0] l_spd, input logic l_rev,
                             input logic [10:0] r_spd, input logic r_rev);
      c_lf = 0; c_lr = 0; c_rf = 0; c_rr = 0; c_ps = 0;
      for (int i = 0; i < 2048; i++) begin
         @(negedge clk);
         c_lf += int'(lft_fwd_pwm);
         c_lr += int'(lft_rev_pwm);
         c_rf += int'(rght_fwd_pwm);
         c_rr += int'(rght_rev_pwm);
         c_ps += int'(period_sync);
         ps_last = period_sync;
         if (i == ev_at && kind == 1) begin
            lft_spd = l_spd; lft_rev = l_rev; rght_spd = r_spd; rght_rev = r_rev;
         end
         if (i == ev_at && kind == 2) en = 1'b0;
         if (i == ev_at + 100 && kind == 2) en = 1'b1;
      end
      check("psync_count", c_ps, 1);
      check("psync_at_end", ps_last, 1);
   endtask

   task automatic expect_counts(input string tag, input int lf, input int lr, input int rf, input int rr);
      check({tag, "_lf"}, c_lf, lf);
      check({tag, "_lr"}, c_lr, lr);
      check({tag, "_rf"}, c_rf, rf);
      check({tag, "_rr"}, c_rr, rr);
   endtask

   initial begin
      rst = 1'b1; en = 1'b1;
      lft_spd = 11'h400; lft_rev = 1'b0; rght_spd = 11'h200; rght_rev = 1'b0;
      @(negedge clk);
      check("reset_outs", {lft_fwd_pwm, lft_rev_pwm, rght_fwd_pwm, rght_rev_pwm, period_sync}, 0);
      @(negedge clk);
      rst = 1'b0;
      sync_to_boundary();

      run_period(-1, 0, 0, 0, 0, 0);
      expect_counts("base", 1024, 0, 512, 0);
      run_period(500, 1, 11'h100, 1'b0, 11'h200, 1'b0);
      expect_counts("spdchg_cur", 1024, 0, 512, 0);
      run_period(1000, 1, 11'h7FF, 1'b1, 11'h200, 1'b0);
      expect_counts("spdchg_next", 256, 0, 512, 0);
      run_period(10, 1, 11'h7FF, 1'b1, 11'h000, 1'b0);
      expect_counts("flip_dead", 0, 2048 - 1 - DEAD, 512, 0);
      run_period(10, 1, 11'h000, 1'b1, 11'h7FF, 1'b0);
      expect_counts("max_lft", 0, 2047, 0, 0);
      run_period(10, 1, 11'h400, 1'b0, 11'h400, 1'b0);
      expect_counts("max_rght", 0, 0, 2047, 0);
      run_period(-1, 0, 0, 0, 0, 0);
      expect_counts("unflip", 992, 0, 1024, 0);
      run_period(300, 2, 0, 0, 0, 0);
      expect_counts("en_drop", 924, 0, 924, 0);
      run_period(1500, 1, 11'h400, 1'b1, 11'h400, 1'b0);
      expect_counts("resume", 1024, 0, 1024, 0);

      // Left is now in DEAD and right is in its high phase; reset must clear both at once.
      repeat (10) @(negedge clk);
      check("pre_rst_rght_high", rght_fwd_pwm, 1);
      check("pre_rst_lft_dead", {lft_fwd_pwm, lft_rev_pwm}, 0);
      rst = 1'b1;
      @(negedge clk);
      check("rst_outs", {lft_fwd_pwm, lft_rev_pwm, rght_fwd_pwm, rght_rev_pwm, period_sync}, 0);
      rst = 1'b0;
      c_lf = 0; c_ps = 0;
      for (int i = 1; i < 2048; i++) begin
         @(negedge clk);
         c_lf += int'(lft_fwd_pwm) + int'(lft_rev_pwm) + int'(rght_fwd_pwm) + int'(rght_rev_pwm);
         c_ps += int'(period_sync);
         ps_last = period_sync;
      end
      check("post_rst_quiet", c_lf, 0);
      check("post_rst_psync", c_ps, 1);
      check("post_rst_psync_end", ps_last, 1);
      run_period(-1, 0, 0, 0, 0, 0);
      expect_counts("post_rst", 0, 992, 1024, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mtr_drv.md
Name: mtr_drv

Overview:
- Consumes the signed-magnitude wheel commands from the balance controller (11-bit speed plus reverse flag per side).
- Converts each side into a pair of H-bridge PWM drives (forward and reverse leg) from one shared 11-bit PWM timebase.
- Duty and direction are updated only at PWM period boundaries.
- Dead time is inserted on every direction reversal so the two legs are never driven together.

Parameters:
- DEAD_CYCLES, 32, cycles both legs of a side are held low after a direction change (legal range 1..255).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- en  in  1  drive enable; low forces all PWM outputs low
- lft_spd  in  11  left magnitude (unsigned duty, 0..2047)
- lft_rev  in  1  left direction (1 = reverse)
- rght_spd  in  11  right magnitude
- rght_rev  in  1  right direction
- lft_fwd_pwm  out  1  left forward-leg drive
- lft_rev_pwm  out  1  left reverse-leg drive
- rght_fwd_pwm  out  1  right forward-leg drive
- rght_rev_pwm  out  1  right reverse-leg drive
- period_sync  out  1  one-cycle pulse on the cycle cnt==2047

Behaviour:
- Timebase: 11-bit free-running cnt, 0..2047, wraps to 0. Period is 2048 clk. rst sets cnt=0.
- Boundary: when cnt==2047, each side registers duty_reg<=spd and dir_req<=rev at that clock edge. Inputs changing at any other time have no effect. period_sync is registered and high during the cycle cnt==2047.
- Per-side FSM, identical and independent, states FWD, REV, DEAD:
  - At a boundary, if dir_req differs from the current direction (FWD=0, REV=1): go to DEAD, load dead_cnt=DEAD_CYCLES, latch tgt_dir.
  - At a boundary, if the direction is unchanged: stay in the current state.
  - DEAD decrements dead_cnt each cycle. When dead_cnt==1, it enters tgt_dir on the next edge.
  - A boundary arriving while in DEAD (only possible if DEAD_CYCLES>2047, i.e. never in the legal range) is ignored.
- Compare: active = (cnt < duty_reg).
  - Outputs are registered: the output during cycle n reflects state, active and en from cycle n-1. This gives one cycle of latency against cnt.
  - fwd_pwm <= en & (state==FWD) & active.
  - rev_pwm <= en & (state==REV) & active.
  - In DEAD, both legs are 0.
- Duty edge cases:
  - duty_reg==0: leg never high.
  - duty_reg==2047: high 2047 of 2048 cycles. 100% is not reachable by design.
- Invariant: fwd_pwm & rev_pwm is never 1 for a side, in any cycle, including around reset and en toggles.
- en only gates the outputs. cnt, duty_reg and the FSMs keep running while en is low. Re-enabling resumes on the next cycle with no resync.
- Reset:
  - All outputs are 0 the cycle after rst is sampled high.
  - State=FWD, duty_reg=0, dead_cnt=0, cnt=0.
  - Reset mid-DEAD or mid-period aborts it immediately. No dead time is applied after reset, because outputs are already low and duty is 0 until the next boundary.
- Simultaneous events: a direction flip with a spd change at the same boundary loads the new duty and enters DEAD together. The new duty takes effect when DEAD exits, within the same period.

Test Plan:
- Reset, en=1, lft_spd=0x400, lft_rev=0: after the first boundary, lft_fwd_pwm high exactly 1024 of every 2048 cycles, high for cnt 0..1023 (output lagged one cycle); lft_rev_pwm stays 0.
- lft_spd changed 0x400->0x100 at cnt=500: current period keeps a 1024-cycle high; next period high 256 cycles.
- lft_rev 0->1 with spd=0x7FF, DEAD_CYCLES=32: after the boundary, both left legs are 0 for 32 cycles, then lft_rev_pwm is high until cnt reaches 2047. Right side is unaffected. fwd&rev is never 1 (checked every cycle by assertion).
- spd=0 and spd=0x7FF on both sides: outputs constantly 0, and high 2047/2048 respectively. period_sync pulses exactly every 2048 cycles.
- en dropped for 100 cycles mid-period at duty 0x400: outputs 0 during that window; they resume the cycle after en returns, with the same cnt alignment.
- rst asserted during DEAD and during a high phase: all outputs 0 next cycle; after release, cnt restarts at 0 and outputs stay 0 until the first boundary loads a nonzero duty.
